// File: rtl/multi_road_signal_ctrl_pkg.sv
// Shared lamp codes, controller state encodings and small sizing helpers
// for the multi-road traffic-signal controller.
package multi_road_signal_ctrl_pkg;

    // Lamp driver encoding, identical for the main road and every side road.
    typedef enum logic [1:0] {
        LAMP_RED    = 2'd0,
        LAMP_YELLOW = 2'd1,
        LAMP_GREEN  = 2'd2,
        LAMP_OFF    = 2'd3
    } lamp_e;

    // Controller states; encoding 3'd7 is unused and recovers to ST_MAIN_GRN.
    typedef enum logic [2:0] {
        ST_MAIN_GRN    = 3'd0,
        ST_MAIN_YEL    = 3'd1,
        ST_RED_TO_SIDE = 3'd2,
        ST_SIDE_GRN    = 3'd3,
        ST_SIDE_YEL    = 3'd4,
        ST_RED_TO_MAIN = 3'd5,
        ST_FLASH       = 3'd6
    } state_e;

    // Index width for n side roads; a single road still needs one bit.
    function automatic int idx_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/multi_road_signal_ctrl_pick.sv
// Combinational round-robin picker: returns the first requesting side road
// at or after the pointer, wrapping modulo NUM_SIDE.
module multi_road_signal_ctrl_pick #(
    parameter int NUM_SIDE = 2,
    parameter int IDX_W    = 1
) (
    input  logic [NUM_SIDE-1:0] req_i,
    input  logic [IDX_W-1:0]    ptr_i,
    output logic [IDX_W-1:0]    idx_o,
    output logic                valid_o
);

    // Scan requests starting from the pointer; first hit wins.
    always_comb begin
        int                cand;
        logic [IDX_W-1:0]  cand_idx;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_SIDE; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= NUM_SIDE) begin
                cand = cand - NUM_SIDE;
            end else begin
                cand = cand;
            end
            cand_idx = IDX_W'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o = 1'b1;
                idx_o   = cand_idx;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/multi_road_signal_ctrl.sv
// Traffic-signal controller: main road rests on green, side roads are served
// round-robin on request, with min/max side green and a flash mode.
// All lamp outputs are registered from the next-state decode so lamps change
// on the edge that enters a state.
module multi_road_signal_ctrl
    import multi_road_signal_ctrl_pkg::*;
#(
    parameter  int NUM_SIDE       = 2,
    parameter  int MIN_GREEN      = 8,
    parameter  int MIN_SIDE_GREEN = 2,
    parameter  int MAX_SIDE_GREEN = 10,
    parameter  int Y2R_DELAY      = 3,
    parameter  int R2G_DELAY      = 2,
    parameter  int FLASH_HALF     = 4,
    parameter  int TIMER_W        = 8,
    localparam int IDX_W          = idx_width(NUM_SIDE)
) (
    input  logic                  CLOCK,
    input  logic                  CLEAR_N,
    input  logic [NUM_SIDE-1:0]   CAR_ON_SIDE_RD,
    input  logic                  FLASH_EN,
    output logic [1:0]            MAIN_SIG,
    output logic [2*NUM_SIDE-1:0] SIDE_SIG,
    output logic [IDX_W-1:0]      ACTIVE_SIDE
);

    // Last timer value of each dwell (timer counts 0..D-1 inside a state of D cycles).
    localparam logic [TIMER_W-1:0] T_MIN_GREEN = TIMER_W'(MIN_GREEN - 1);
    localparam logic [TIMER_W-1:0] T_MIN_SIDE  = TIMER_W'(MIN_SIDE_GREEN - 1);
    localparam logic [TIMER_W-1:0] T_MAX_SIDE  = TIMER_W'(MAX_SIDE_GREEN - 1);
    localparam logic [TIMER_W-1:0] T_Y2R       = TIMER_W'(Y2R_DELAY - 1);
    localparam logic [TIMER_W-1:0] T_R2G       = TIMER_W'(R2G_DELAY - 1);
    localparam logic [TIMER_W-1:0] T_FLASH     = TIMER_W'(FLASH_HALF - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_SIDE - 1);

    state_e                state_q, state_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [TIMER_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                  blink_q, blink_d;
    logic [IDX_W-1:0]      sel_q, sel_d;
    logic [IDX_W-1:0]      rr_q, rr_d;
    logic [IDX_W-1:0]      pick_idx_s;
    logic                  pick_valid_s;
    logic                  req_sel_s;
    lamp_e                 main_q, main_d;
    logic [2*NUM_SIDE-1:0] side_q, side_d;

    multi_road_signal_ctrl_pick #(
        .NUM_SIDE (NUM_SIDE),
        .IDX_W    (IDX_W)
    ) u_pick (
        .req_i   (CAR_ON_SIDE_RD),
        .ptr_i   (rr_q),
        .idx_o   (pick_idx_s),
        .valid_o (pick_valid_s)
    );

    assign req_sel_s = CAR_ON_SIDE_RD[sel_q];

    // State register.
    always_ff @(posedge CLOCK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            state_q <= ST_MAIN_GRN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, selection latch and round-robin pointer advance.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        case (state_q)
            ST_MAIN_GRN: begin
                if (FLASH_EN) begin
                    state_d = ST_FLASH;
                end else if ((timer_q >= T_MIN_GREEN) && pick_valid_s) begin
                    state_d = ST_MAIN_YEL;
                    sel_d   = pick_idx_s;
                end else begin
                    state_d = ST_MAIN_GRN;
                end
            end
            ST_MAIN_YEL: begin
                if (timer_q >= T_Y2R) begin
                    state_d = ST_RED_TO_SIDE;
                end else begin
                    state_d = ST_MAIN_YEL;
                end
            end
            ST_RED_TO_SIDE: begin
                if (timer_q >= T_R2G) begin
                    state_d = ST_SIDE_GRN;
                end else begin
                    state_d = ST_RED_TO_SIDE;
                end
            end
            ST_SIDE_GRN: begin
                if (((timer_q >= T_MIN_SIDE) && !req_sel_s) || (timer_q >= T_MAX_SIDE)) begin
                    state_d = ST_SIDE_YEL;
                end else begin
                    state_d = ST_SIDE_GRN;
                end
            end
            ST_SIDE_YEL: begin
                if (timer_q >= T_Y2R) begin
                    state_d = ST_RED_TO_MAIN;
                    if (sel_q == LAST_IDX) begin
                        rr_d = '0;
                    end else begin
                        rr_d = sel_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ST_SIDE_YEL;
                end
            end
            ST_RED_TO_MAIN: begin
                if (timer_q >= T_R2G) begin
                    state_d = ST_MAIN_GRN;
                end else begin
                    state_d = ST_RED_TO_MAIN;
                end
            end
            ST_FLASH: begin
                if (!FLASH_EN) begin
                    state_d = ST_RED_TO_MAIN;
                end else begin
                    state_d = ST_FLASH;
                end
            end
            default: begin
                state_d = ST_MAIN_GRN;
            end
        endcase
    end

    // Dwell timer (cleared on state entry, saturating) and flash blink phase.
    always_comb begin
        timer_d     = timer_q;
        blink_d     = 1'b0;
        blink_cnt_d = '0;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != {TIMER_W{1'b1}}) begin
            timer_d = timer_q + TIMER_W'(1);
        end else begin
            timer_d = timer_q;
        end
        if ((state_d == ST_FLASH) && (state_q == ST_FLASH)) begin
            if (blink_cnt_q >= T_FLASH) begin
                blink_d     = ~blink_q;
                blink_cnt_d = '0;
            end else begin
                blink_d     = blink_q;
                blink_cnt_d = blink_cnt_q + TIMER_W'(1);
            end
        end else begin
            blink_d     = 1'b0;
            blink_cnt_d = '0;
        end
    end

    // Lamp decode from the state being entered.
    always_comb begin
        side_d = '0;
        case (state_d)
            ST_MAIN_GRN: main_d = LAMP_GREEN;
            ST_MAIN_YEL: main_d = LAMP_YELLOW;
            ST_FLASH:    main_d = blink_d ? LAMP_OFF : LAMP_YELLOW;
            default:     main_d = LAMP_RED;
        endcase
        for (int i = 0; i < NUM_SIDE; i++) begin
            if ((state_d == ST_SIDE_GRN) && (sel_d == IDX_W'(i))) begin
                side_d[2*i +: 2] = LAMP_GREEN;
            end else if ((state_d == ST_SIDE_YEL) && (sel_d == IDX_W'(i))) begin
                side_d[2*i +: 2] = LAMP_YELLOW;
            end else if (state_d == ST_FLASH) begin
                side_d[2*i +: 2] = blink_d ? LAMP_OFF : LAMP_RED;
            end else begin
                side_d[2*i +: 2] = LAMP_RED;
            end
        end
    end

    // Datapath registers: timer, blink counter/phase, selection and pointer.
    always_ff @(posedge CLOCK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            timer_q     <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            sel_q       <= '0;
            rr_q        <= '0;
        end else begin
            timer_q     <= timer_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            sel_q       <= sel_d;
            rr_q        <= rr_d;
        end
    end

    // Registered lamp outputs.
    always_ff @(posedge CLOCK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            main_q <= LAMP_GREEN;
            side_q <= '0;
        end else begin
            main_q <= main_d;
            side_q <= side_d;
        end
    end

    assign MAIN_SIG    = main_q;
    assign SIDE_SIG    = side_q;
    assign ACTIVE_SIDE = sel_q;

endmodule

// File: tb/tb_multi_road_signal_ctrl.sv
// Scoreboard bench for multi_road_signal_ctrl with default parameters.
// A cycle model counting elapsed cycles per state predicts the lamps after
// each clock edge; predictions are queued and compared once the edge is past.
module tb_multi_road_signal_ctrl;

    localparam int NS         = 2;
    localparam int MIN_GREEN  = 8;
    localparam int MIN_SIDE   = 2;
    localparam int MAX_SIDE   = 10;
    localparam int Y2R        = 3;
    localparam int R2G        = 2;
    localparam int FLASH_HALF = 4;

    localparam int M_MG = 0;
    localparam int M_MY = 1;
    localparam int M_RS = 2;
    localparam int M_SG = 3;
    localparam int M_SY = 4;
    localparam int M_RM = 5;
    localparam int M_FL = 6;

    typedef struct {
        int main_v;
        int side_v;
        int act_v;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [NS-1:0] req;
    logic          flash;
    logic [1:0]    main_sig;
    logic [2*NS-1:0] side_sig;
    logic [0:0]    active;

    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];

    int m_st;
    int m_age;
    int m_sel;
    int m_rr;
    int m_phase;
    int m_bage;

    multi_road_signal_ctrl dut (
        .CLOCK          (clk),
        .CLEAR_N        (rst_n),
        .CAR_ON_SIDE_RD (req),
        .FLASH_EN       (flash),
        .MAIN_SIG       (main_sig),
        .SIDE_SIG       (side_sig),
        .ACTIVE_SIDE    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs != expv) begin
            n_errors++;
            $display("FAIL %s @%0t: observed %0d expected %0d", tag, $time, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_st    = M_MG;
        m_age   = 1;
        m_sel   = 0;
        m_rr    = 0;
        m_phase = 0;
        m_bage  = 1;
    endtask

    // Advance the model across one clock edge given the inputs at that edge.
    task automatic model_step(input logic [NS-1:0] r, input logic f);
        int nst;
        int found;
        nst = m_st;
        case (m_st)
            M_MG: begin
                if (f) begin
                    nst = M_FL;
                end else if (m_age >= MIN_GREEN && r != '0) begin
                    nst   = M_MY;
                    found = 0;
                    for (int k = 0; k < NS; k++) begin
                        if (found == 0 && r[(m_rr + k) % NS]) begin
                            m_sel = (m_rr + k) % NS;
                            found = 1;
                        end
                    end
                end
            end
            M_MY: if (m_age == Y2R) nst = M_RS;
            M_RS: if (m_age == R2G) nst = M_SG;
            M_SG: if ((m_age >= MIN_SIDE && !r[m_sel]) || m_age >= MAX_SIDE) nst = M_SY;
            M_SY: begin
                if (m_age == Y2R) begin
                    nst  = M_RM;
                    m_rr = (m_sel + 1) % NS;
                end
            end
            M_RM: if (m_age == R2G) nst = M_MG;
            M_FL: if (!f) nst = M_RM;
            default: nst = M_MG;
        endcase
        if (nst == M_FL && m_st == M_FL) begin
            if (m_bage == FLASH_HALF) begin
                m_phase = 1 - m_phase;
                m_bage  = 1;
            end else begin
                m_bage++;
            end
        end else begin
            m_phase = 0;
            m_bage  = 1;
        end
        if (nst == m_st) m_age++;
        else m_age = 1;
        m_st = nst;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        case (m_st)
            M_MG:    e.main_v = 2;
            M_MY:    e.main_v = 1;
            M_FL:    e.main_v = (m_phase != 0) ? 3 : 1;
            default: e.main_v = 0;
        endcase
        e.side_v = 0;
        for (int i = 0; i < NS; i++) begin
            int v;
            v = 0;
            if (m_st == M_SG && m_sel == i) v = 2;
            else if (m_st == M_SY && m_sel == i) v = 1;
            else if (m_st == M_FL) v = (m_phase != 0) ? 3 : 0;
            e.side_v = e.side_v | (v << (2 * i));
        end
        e.act_v = m_sel;
        return e;
    endfunction

    // One clock: predict, queue, let the edge pass, compare the oldest prediction.
    task automatic step();
        exp_t e;
        model_step(req, flash);
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check_eq("main_sig", int'(main_sig), e.main_v);
            check_eq("side_sig", int'(side_sig), e.side_v);
            check_eq("active_side", int'(active), e.act_v);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_side_green(input int road, input string tag);
        int k;
        k = 0;
        while (k < 60 && side_sig[2*road +: 2] != 2'd2) begin
            step();
            k++;
        end
        check_eq(tag, (k < 60) ? 1 : 0, 1);
    endtask

    task automatic wait_main_green(input string tag);
        int k;
        k = 0;
        while (k < 60 && main_sig != 2'd2) begin
            step();
            k++;
        end
        check_eq(tag, (k < 60) ? 1 : 0, 1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        req      = '0;
        flash    = 1'b0;
        model_reset();
        #12;
        check_eq("rst_main", int'(main_sig), 2);
        check_eq("rst_side", int'(side_sig), 0);
        check_eq("rst_active", int'(active), 0);
        rst_n = 1'b1;

        // 1: idle main green.
        run(100);

        // 2: side 1 request, dropped after 5 cycles of side green.
        req = 2'b10;
        wait_side_green(1, "t2_side1_green");
        run(4);
        req = 2'b00;
        step();
        check_eq("t2_side1_yellow", int'(side_sig[3:2]), 1);
        wait_main_green("t2_back_main");

        // 4b: request held from main-green timer 2; side 0 gets minimum green.
        run(2);
        req = 2'b01;
        wait_side_green(0, "t4_side0_green");
        req = 2'b00;
        wait_main_green("t4_back_main");

        // 4a: one-cycle pulse at timer 2 is not latched.
        run(2);
        req = 2'b01;
        step();
        req = 2'b00;
        run(15);
        check_eq("t4_pulse_ignored", int'(main_sig), 2);

        // 3: both roads held -> alternating max-length services.
        req = 2'b11;
        run(90);
        req = 2'b00;
        run(40);

        // 5: flash from main green, then flash requested during a side service.
        flash = 1'b1;
        run(20);
        flash = 1'b0;
        run(10);
        req = 2'b01;
        wait_side_green(0, "t5_side0_green");
        flash = 1'b1;
        run(30);
        flash = 1'b0;
        req   = 2'b00;
        run(12);

        // 6: asynchronous reset in the middle of side green.
        req = 2'b10;
        wait_side_green(1, "t6_side1_green");
        run(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_main", int'(main_sig), 2);
        check_eq("t6_async_side", int'(side_sig), 0);
        check_eq("t6_async_active", int'(active), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("t6_hold_main", int'(main_sig), 2);
        model_reset();
        rst_n = 1'b1;
        req   = 2'b11;
        run(12);
        check_eq("t6_first_served", int'(active), 0);
        run(40);
        req = 2'b00;
        run(30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
